// File: rtl/imem_boot_ctrl.sv
// Boot loader: streams words into imem port B and holds the core in reset until loaded.
// Optional checksum beat and CHECK/ERR states are enabled with macro BOOT_CHECKSUM_EN.

module imem_boot_ctrl #(
   parameter int unsigned I_DATAWIDTH    = 32,
   parameter int unsigned I_ADDRESSWIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [31:0]             base_addr,
   input  logic [I_ADDRESSWIDTH:0] word_count,
   input  logic                    s_valid,
   input  logic [I_DATAWIDTH-1:0]  s_data,
   output logic                    s_ready,
   output logic [31:0]             boot_iaddr,
   output logic [I_DATAWIDTH-1:0]  boot_idata,
   output logic                    boot_iwe,
   output logic                    core_resetn,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int unsigned DW = I_DATAWIDTH;
   localparam int unsigned CW = I_ADDRESSWIDTH + 1;

`ifdef BOOT_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERR} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
`endif

   state_t          state, state_nxt;
   logic [CW-1:0]   idx, idx_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic [31:0]     base, base_nxt;
   logic [31:0]     iaddr_nxt;
   logic [DW-1:0]   idata_nxt;
   logic            iwe_nxt;
   logic            rstn_nxt;
   logic            busy_nxt;
   logic            done_nxt;
   logic            beat;
   logic            last_beat;

`ifdef BOOT_CHECKSUM_EN
   logic [DW-1:0]   sum, sum_nxt;
   logic            error_nxt;

   assign s_ready = ((state == LOAD) && (idx < count)) || (state == CHECK);
`else
   assign s_ready = (state == LOAD) && (idx < count);
   assign error   = 1'b0;
`endif

   assign beat      = s_valid & s_ready;
   assign last_beat = (CW'(idx + CW'(1)) == count);

   // Next-state and next-output logic
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      count_nxt = count;
      base_nxt  = base;
      iaddr_nxt = boot_iaddr;
      idata_nxt = boot_idata;
      iwe_nxt   = 1'b0;
      rstn_nxt  = core_resetn;
      done_nxt  = 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_nxt   = sum;
      error_nxt = error;
`endif
      case (state)
         IDLE, RUN
`ifdef BOOT_CHECKSUM_EN
         , ERR
`endif
         : begin
            if (start) begin
               base_nxt  = base_addr;
               count_nxt = word_count;
               idx_nxt   = '0;
               rstn_nxt  = 1'b0;
`ifdef BOOT_CHECKSUM_EN
               sum_nxt   = '0;
               error_nxt = 1'b0;
               state_nxt = (word_count == '0) ? CHECK : LOAD;
`else
               if (word_count == '0) begin
                  state_nxt = RUN;
                  rstn_nxt  = 1'b1;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = LOAD;
               end
`endif
            end
         end
         LOAD: begin
            if (beat) begin
               iwe_nxt   = 1'b1;
               idata_nxt = s_data;
               iaddr_nxt = base + 32'(idx);
               idx_nxt   = CW'(idx + CW'(1));
`ifdef BOOT_CHECKSUM_EN
               sum_nxt   = sum + s_data;
               if (last_beat) state_nxt = CHECK;
`else
               // Core leaves reset in the same cycle the final word is written
               if (last_beat) begin
                  state_nxt = RUN;
                  rstn_nxt  = 1'b1;
                  done_nxt  = 1'b1;
               end
`endif
            end
         end
`ifdef BOOT_CHECKSUM_EN
         CHECK: begin
            if (beat) begin
               if (s_data == sum) begin
                  state_nxt = RUN;
                  rstn_nxt  = 1'b1;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = ERR;
                  error_nxt = 1'b1;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
`ifdef BOOT_CHECKSUM_EN
      busy_nxt = (state_nxt == LOAD) || (state_nxt == CHECK);
`else
      busy_nxt = (state_nxt == LOAD);
`endif
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         count       <= '0;
         base        <= '0;
         boot_iaddr  <= '0;
         boot_idata  <= '0;
         boot_iwe    <= 1'b0;
         core_resetn <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         sum         <= '0;
         error       <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         count       <= count_nxt;
         base        <= base_nxt;
         boot_iaddr  <= iaddr_nxt;
         boot_idata  <= idata_nxt;
         boot_iwe    <= iwe_nxt;
         core_resetn <= rstn_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
`ifdef BOOT_CHECKSUM_EN
         sum         <= sum_nxt;
         error       <= error_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: expected imem writes are queued on each accepted beat
// and checked by a monitor when boot_iwe appears.

module tb_imem_boot_ctrl;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 8;
   localparam int unsigned CW = AW + 1;

   logic          clk;
   logic          reset;
   logic          start;
   logic [31:0]   base_addr;
   logic [CW-1:0] word_count;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic [31:0]   boot_iaddr;
   logic [DW-1:0] boot_idata;
   logic          boot_iwe;
   logic          core_resetn;
   logic          busy;
   logic          done;
   logic          error;

   typedef struct packed {
      logic [31:0]   a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           exp_q[$];
   wr_t           mon_e;
   int            checks   = 0;
   int            failures = 0;
   int            done_cnt = 0;
   logic [DW-1:0] wbuf [16];

   imem_boot_ctrl #(.I_DATAWIDTH(DW), .I_ADDRESSWIDTH(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .word_count(word_count), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .boot_iaddr(boot_iaddr), .boot_idata(boot_idata), .boot_iwe(boot_iwe),
      .core_resetn(core_resetn), .busy(busy), .done(done), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor: every imem write must match the oldest accepted beat
   always @(negedge clk) begin
      if (boot_iwe === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected addr=%h data=%h", boot_iaddr, boot_idata);
         end else begin
            mon_e = exp_q.pop_front();
            if (boot_iaddr !== mon_e.a || boot_idata !== mon_e.d) begin
               failures++;
               $display("FAIL wr_data got addr=%h data=%h exp addr=%h data=%h",
                        boot_iaddr, boot_idata, mon_e.a, mon_e.d);
            end
         end
      end
      if (done === 1'b1) done_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic fill(input logic [DW-1:0] first, input int n);
      for (int i = 0; i < n; i++) wbuf[i] = first + DW'(i);
   endtask

   task automatic do_start(input logic [31:0] b, input int n);
      base_addr  = b;
      word_count = CW'(n);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic stream(input logic [31:0] b, input int n, input bit stall,
                         input int start_at, output int cycles);
      int  i = 0;
      int  t = 0;
      wr_t e;
      while (i < n && t < 200) begin
         s_valid = stall ? (t % 3 == 0) : 1'b1;
         s_data  = wbuf[i];
         if (t == start_at) begin
            start      = 1'b1;
            base_addr  = 32'h55;
            word_count = CW'(1);
         end
         @(negedge clk);
         if (s_valid && s_ready) begin
            e.a = b + 32'(i);
            e.d = wbuf[i];
            exp_q.push_back(e);
            i++;
         end
         @(posedge clk); #1;
         start = 1'b0;
         t++;
      end
      s_valid = 1'b0;
      cycles  = t;
      checks++;
      if (i != n) begin
         failures++;
         $display("FAIL stream_timeout accepted=%0d exp=%0d", i, n);
      end
   endtask

   // Waits for load completion right after the last data beat
   task automatic check_complete(input int n);
`ifdef BOOT_CHECKSUM_EN
      logic [DW-1:0] s = '0;
      for (int i = 0; i < n; i++) s = s + wbuf[i];
      s_valid = 1'b1;
      s_data  = s;
      @(posedge clk); #1;
      s_valid = 1'b0;
`endif
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || core_resetn !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL complete n=%0d got done=%b core_resetn=%b busy=%b exp 1 1 0",
                  n, done, core_resetn, busy);
      end
`ifndef BOOT_CHECKSUM_EN
      checks++;
      if (boot_iwe !== 1'b1) begin
         failures++;
         $display("FAIL complete_with_write got boot_iwe=%b exp 1", boot_iwe);
      end
`endif
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse got done=%b exp 0", done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
      s_valid = 1'b0; s_data = '0;
      #12;
      checks++;
      if ({s_ready, boot_iwe, core_resetn, busy, done, error} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl got %b exp 000000",
                  {s_ready, boot_iwe, core_resetn, busy, done, error});
      end
      checks++;
      if (boot_iaddr !== 32'h0 || boot_idata !== '0) begin
         failures++;
         $display("FAIL reset_bus got addr=%h data=%h exp 0 0", boot_iaddr, boot_idata);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (core_resetn !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_hold got core_resetn=%b busy=%b s_ready=%b exp 0 0 0",
                  core_resetn, busy, s_ready);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int d0;
      fill(32'hA0, 4);
      d0 = done_cnt;
      do_start(32'h10, 4);
      stream(32'h10, 4, 1'b0, -1, cyc);
      checks++;
      if (cyc != 4) begin
         failures++;
         $display("FAIL b2b_cycles got %0d exp 4", cyc);
      end
      check_complete(4);
      // Beats in RUN must be refused
      s_valid = 1'b1; s_data = 32'hBAD;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin
         failures++;
         $display("FAIL run_ready got %b exp 0", s_ready);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (done_cnt - d0 != 1) begin
         failures++;
         $display("FAIL done_count got %0d exp 1", done_cnt - d0);
      end
   endtask

   task automatic test_stall();
      int cyc;
      fill(32'hB0, 4);
      do_start(32'h20, 4);
      stream(32'h20, 4, 1'b1, -1, cyc);
      checks++;
      if (cyc != 10) begin
         failures++;
         $display("FAIL stall_cycles got %0d exp 10", cyc);
      end
      check_complete(4);
   endtask

   task automatic test_zero_count();
      do_start(32'h30, 0);
`ifdef BOOT_CHECKSUM_EN
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || s_ready !== 1'b1 || core_resetn !== 1'b0) begin
         failures++;
         $display("FAIL zero_check got busy=%b s_ready=%b core_resetn=%b exp 1 1 0",
                  busy, s_ready, core_resetn);
      end
      @(posedge clk); #1;
      check_complete(0);
`else
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || core_resetn !== 1'b1 || busy !== 1'b0 || boot_iwe !== 1'b0) begin
         failures++;
         $display("FAIL zero_count got done=%b core_resetn=%b busy=%b iwe=%b exp 1 1 0 0",
                  done, core_resetn, busy, boot_iwe);
      end
      @(posedge clk); #1;
`endif
   endtask

   task automatic test_start_ignored();
      int cyc;
      fill(32'hC0, 4);
      do_start(32'h40, 4);
      stream(32'h40, 4, 1'b0, 2, cyc);
      checks++;
      if (cyc != 4) begin
         failures++;
         $display("FAIL ignore_cycles got %0d exp 4", cyc);
      end
      check_complete(4);
   endtask

   task automatic test_reset_mid_load();
      int cyc;
      fill(32'hD0, 4);
      do_start(32'h60, 4);
      stream(32'h60, 2, 1'b0, -1, cyc);
      s_valid = 1'b1; s_data = wbuf[2];
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({s_ready, boot_iwe, core_resetn, busy, done} !== 5'b0 || boot_iaddr !== 32'h0) begin
         failures++;
         $display("FAIL async_reset got ctrl=%b addr=%h exp 00000 0",
                  {s_ready, boot_iwe, core_resetn, busy, done}, boot_iaddr);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL partial_writes got pending=%0d exp 0", exp_q.size());
      end
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (core_resetn !== 1'b0 || busy !== 1'b0 || boot_iwe !== 1'b0) begin
         failures++;
         $display("FAIL post_reset got core_resetn=%b busy=%b iwe=%b exp 0 0 0",
                  core_resetn, busy, boot_iwe);
      end
   endtask

   task automatic test_addr_wrap();
      int cyc;
      fill(32'hE0, 4);
      do_start(32'hFE, 4);
      stream(32'hFE, 4, 1'b0, -1, cyc);
      check_complete(4);
      checks++;
      if (boot_iaddr !== 32'h101) begin
         failures++;
         $display("FAIL wrap_addr got %h exp 00000101", boot_iaddr);
      end
   endtask

   task automatic test_start_in_run();
      int cyc;
      fill(32'hF0, 2);
      base_addr = 32'h80; word_count = CW'(2);
      start = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin
         failures++;
         $display("FAIL start_wins got s_ready=%b exp 0", s_ready);
      end
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || core_resetn !== 1'b0) begin
         failures++;
         $display("FAIL restart_state got busy=%b core_resetn=%b exp 1 0", busy, core_resetn);
      end
      @(posedge clk); #1;
      stream(32'h80, 2, 1'b0, -1, cyc);
      check_complete(2);
   endtask

`ifdef BOOT_CHECKSUM_EN
   task automatic test_checksum();
      int cyc;
      wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
      do_start(32'h0, 3);
      stream(32'h0, 3, 1'b0, -1, cyc);
      check_complete(3);
      checks++;
      if (error !== 1'b0) begin
         failures++;
         $display("FAIL csum_good got error=%b exp 0", error);
      end
      do_start(32'h0, 3);
      stream(32'h0, 3, 1'b0, -1, cyc);
      s_valid = 1'b1; s_data = 32'd7;
      @(posedge clk); #1;
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (error !== 1'b1 || core_resetn !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL csum_bad got error=%b core_resetn=%b done=%b busy=%b exp 1 0 0 0",
                  error, core_resetn, done, busy);
      end
      do_start(32'h0, 3);
      checks++;
      if (error !== 1'b0) begin
         failures++;
         $display("FAIL csum_clear got error=%b exp 0", error);
      end
      stream(32'h0, 3, 1'b0, -1, cyc);
      check_complete(3);
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_zero_count();
      test_start_ignored();
      test_reset_mid_load();
      test_addr_wrap();
      test_start_in_run();
`ifdef BOOT_CHECKSUM_EN
      test_checksum();
`endif
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_writes got pending=%0d exp 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
